// File: rtl/snake_game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_sequencer_if
// Brief    : Signal bundle between the snake game sequencer and its
//            neighbours (button logic, snake datapath, colour mux, display).
// Revision : 1.0 - initial release
// ============================================================================
interface snake_game_sequencer_if;
    logic       BTN_START;
    logic       REACHED_TARGET;
    logic [1:0] MASTER_STATE;
    logic       GAME_TICK;
    logic [3:0] SCORE;
    logic       NEW_APPLE;
    logic       WIN_FLASH;

    // Sequencer side: consumes button/hit levels, produces game status.
    modport master (
        input  BTN_START,
        input  REACHED_TARGET,
        output MASTER_STATE,
        output GAME_TICK,
        output SCORE,
        output NEW_APPLE,
        output WIN_FLASH
    );

    // Surrounding logic side.
    modport slave (
        output BTN_START,
        output REACHED_TARGET,
        input  MASTER_STATE,
        input  GAME_TICK,
        input  SCORE,
        input  NEW_APPLE,
        input  WIN_FLASH
    );
endinterface
`default_nettype wire

// File: rtl/snake_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snake_game_sequencer
// Brief    : Master game controller for the snake datapath. Runs the
//            IDLE/PLAY/WIN state machine, generates the game-tick strobe,
//            counts the score, requests new apples and drives the win flash.
//            Optional macro SNAKE_SPEEDUP_EN shortens the tick period as the
//            score rises, clamped at MIN_TICK.
// Revision : 1.0 - initial release
// ============================================================================
module snake_game_sequencer #(
    parameter int unsigned TICK_DIV     = 10000000,
    parameter int unsigned TARGET_SCORE = 10,
    parameter int unsigned SPEED_STEP   = 500000,
    parameter int unsigned MIN_TICK     = 2000000
) (
    input wire                     CLK,
    input wire                     RESET,
    snake_game_sequencer_if.master bus
);

`ifdef SNAKE_SPEEDUP_EN
    localparam bit c_SPEEDUP_EN = 1'b1;
`else
    localparam bit c_SPEEDUP_EN = 1'b0;
`endif

    localparam logic [3:0]  c_TARGET     = 4'(TARGET_SCORE);
    localparam logic [39:0] c_TICK_DIV   = 40'(TICK_DIV);
    localparam logic [39:0] c_SPEED_STEP = 40'(SPEED_STEP);
    localparam logic [39:0] c_MIN_TICK   = 40'(MIN_TICK);
    localparam logic [39:0] c_PERIOD_MAX = 40'h00_00FF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_score;
    logic        r_gameTick;
    logic        r_newApple;
    logic        r_winFlash;
    logic        r_btnStartQ;
    logic        r_reachedQ;
    logic [23:0] r_tickCnt;
    logic [23:0] r_period;

    logic        w_startEdge;
    logic        w_hitEdge;
    logic        w_wrap;
    logic [39:0] w_reduction;
    logic [39:0] w_reduced;
    logic [39:0] w_clamped;
    logic [23:0] w_nextPeriod;

    assign w_startEdge = bus.BTN_START & ~r_btnStartQ;
    assign w_hitEdge   = bus.REACHED_TARGET & ~r_reachedQ;
    assign w_wrap      = (r_tickCnt == (r_period - 24'd1));

    // Next tick period from the current score; wide arithmetic so the
    // subtraction saturates at zero before the MIN_TICK floor is applied.
    always_comb begin
        w_reduction  = c_SPEEDUP_EN ? (40'(r_score) * c_SPEED_STEP) : 40'd0;
        w_reduced    = (w_reduction >= c_TICK_DIV) ? 40'd0 : (c_TICK_DIV - w_reduction);
        w_clamped    = (c_SPEEDUP_EN && (w_reduced < c_MIN_TICK)) ? c_MIN_TICK : w_reduced;
        w_nextPeriod = (w_clamped > c_PERIOD_MAX) ? 24'hFF_FFFF : w_clamped[23:0];
    end

    // Game state machine with tick counter, score and registered strobes.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_score     <= 4'd0;
            r_gameTick  <= 1'b0;
            r_newApple  <= 1'b0;
            r_winFlash  <= 1'b0;
            r_btnStartQ <= 1'b0;
            r_reachedQ  <= 1'b0;
            r_tickCnt   <= 24'd0;
            r_period    <= 24'd0;
        end else begin
            r_btnStartQ <= bus.BTN_START;
            r_reachedQ  <= bus.REACHED_TARGET;
            r_gameTick  <= 1'b0;
            r_newApple  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_score    <= 4'd0;
                    r_tickCnt  <= 24'd0;
                    r_winFlash <= 1'b0;
                    if (w_startEdge) begin
                        r_state    <= ST_PLAY;
                        r_newApple <= 1'b1;
                        r_period   <= w_nextPeriod;
                    end
                end

                ST_PLAY: begin
                    // Period is re-latched only at the wrap so a running tick
                    // is never shortened by a score change.
                    if (w_wrap) begin
                        r_tickCnt  <= 24'd0;
                        r_period   <= w_nextPeriod;
                        r_gameTick <= 1'b1;
                    end else begin
                        r_tickCnt  <= r_tickCnt + 24'd1;
                    end
                    if (w_hitEdge) begin
                        r_score <= r_score + 4'd1;
                        if ((r_score + 4'd1) == c_TARGET) begin
                            r_state <= ST_WIN;
                        end else begin
                            r_newApple <= 1'b1;
                        end
                    end
                end

                ST_WIN: begin
                    if (w_startEdge) begin
                        r_state    <= ST_IDLE;
                        r_score    <= 4'd0;
                        r_tickCnt  <= 24'd0;
                        r_winFlash <= 1'b0;
                    end else if (w_wrap) begin
                        r_tickCnt  <= 24'd0;
                        r_period   <= w_nextPeriod;
                        r_winFlash <= ~r_winFlash;
                    end else begin
                        r_tickCnt  <= r_tickCnt + 24'd1;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_score    <= 4'd0;
                    r_tickCnt  <= 24'd0;
                    r_winFlash <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MASTER_STATE = r_state;
    assign bus.GAME_TICK    = r_gameTick;
    assign bus.SCORE        = r_score;
    assign bus.NEW_APPLE    = r_newApple;
    assign bus.WIN_FLASH    = r_winFlash;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_game_sequencer
// Brief    : Scoreboard bench for snake_game_sequencer. A behavioural game
//            model predicts each cycle's outputs into a queue; a monitor
//            pops and compares against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_game_sequencer;
    localparam int TICK_DIV     = 8;
    localparam int TARGET_SCORE = 3;
    localparam int SPEED_STEP   = 2;
    localparam int MIN_TICK     = 4;

    logic CLK;
    logic RESET;

    snake_game_sequencer_if bus ();

    snake_game_sequencer #(
        .TICK_DIV     (TICK_DIV),
        .TARGET_SCORE (TARGET_SCORE),
        .SPEED_STEP   (SPEED_STEP),
        .MIN_TICK     (MIN_TICK)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    logic [8:0] expQ[$];

    // Game model: state 0/1/2, score, cycles elapsed in the current tick.
    int mState, mScore, mElapsed, mPeriod;
    bit mFlash, mPrevBtn, mPrevHit;

    function automatic int periodFor(input int s);
`ifdef SNAKE_SPEEDUP_EN
        int p;
        p = TICK_DIV - s * SPEED_STEP;
        if (p < MIN_TICK) p = MIN_TICK;
        return p;
`else
        return TICK_DIV + 0 * s;
`endif
    endfunction

    task automatic modelReset();
        mState = 0; mScore = 0; mElapsed = 0; mPeriod = 0;
        mFlash = 1'b0; mPrevBtn = 1'b0; mPrevHit = 1'b0;
    endtask

    task automatic modelStep(input bit btn, input bit hit);
        bit startEv, hitEv, tick, apple, boundary;
        startEv  = btn & ~mPrevBtn;
        hitEv    = hit & ~mPrevHit;
        mPrevBtn = btn;
        mPrevHit = hit;
        tick     = 1'b0;
        apple    = 1'b0;
        boundary = 1'b0;
        if (mState != 0) begin
            mElapsed++;
            if (mElapsed == mPeriod) begin
                boundary = 1'b1;
                mElapsed = 0;
                mPeriod  = periodFor(mScore);
            end
        end
        case (mState)
            0: if (startEv) begin
                mState = 1; apple = 1'b1; mElapsed = 0; mPeriod = periodFor(0);
            end
            1: begin
                tick = boundary;
                if (hitEv) begin
                    mScore++;
                    if (mScore == TARGET_SCORE) mState = 2;
                    else apple = 1'b1;
                end
            end
            default: begin
                if (boundary) mFlash = ~mFlash;
                if (startEv) begin
                    mState = 0; mScore = 0; mFlash = 1'b0; mElapsed = 0;
                end
            end
        endcase
        expQ.push_back({2'(mState), tick, 4'(mScore), apple, mFlash});
    endtask

    function automatic logic [8:0] dutOut();
        return {bus.MASTER_STATE, bus.GAME_TICK, bus.SCORE, bus.NEW_APPLE, bus.WIN_FLASH};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d tick=%b score=%0d apple=%b flash=%b, expected state=%0d tick=%b score=%0d apple=%b flash=%b",
                     name, act[8:7], act[6], act[5:2], act[1], act[0],
                     exp[8:7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and predict the result.
    task automatic drive(input bit btn, input bit hit);
        @(negedge CLK);
        bus.BTN_START      = btn;
        bus.REACHED_TARGET = hit;
        modelStep(btn, hit);
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge.
    initial begin
        logic [8:0] exp;
        forever begin
            @(posedge CLK);
            #2;
            cycleNo++;
            if (expQ.size() != 0) begin
                exp = expQ.pop_front();
                check($sformatf("cycle%0d", cycleNo), dutOut(), exp);
            end
        end
    end

    initial begin
        int guard;
        bit hitLvl;
        RESET              = 1'b0;
        bus.BTN_START      = 1'b0;
        bus.REACHED_TARGET = 1'b0;
        modelReset();

        repeat (3) begin
            @(posedge CLK); #2;
            check("resetState", dutOut(), 9'd0);
        end
        #1 RESET = 1'b1;

        // Idle with start held low.
        repeat (50) drive(1'b0, 1'($urandom_range(0, 1)));
        drive(1'b0, 1'b0);

        // Start a game and watch several ticks.
        drive(1'b1, 1'b0);
        repeat (30 + $urandom_range(0, 5)) drive(1'b0, 1'b0);

        // Hit held for 20 cycles with start held too.
        repeat (20) drive(1'b1, 1'b1);
        repeat (10) drive(1'b0, 1'b0);

        // Separate hits until the win.
        guard = 0;
        while (mState != 2 && guard < 20) begin
            repeat ($urandom_range(1, 3)) drive(1'b0, 1'b1);
            repeat ($urandom_range(1, 12)) drive(1'b0, 1'b0);
            guard++;
        end
        repeat (30) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b0);

        // New game up to score 2, then asynchronous reset between edges.
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        guard = 0;
        while (mScore < 2 && guard < 20) begin
            drive(1'b0, 1'b1);
            repeat ($urandom_range(1, 9)) drive(1'b0, 1'b0);
            guard++;
        end
        repeat ($urandom_range(1, 7)) drive(1'b0, 1'b0);
        @(posedge CLK); #3;
        RESET = 1'b0;
        #1 check("asyncReset", dutOut(), 9'd0);
        @(posedge CLK); #2;
        check("resetHeld", dutOut(), 9'd0);
        modelReset();
        #1 RESET = 1'b1;

        drive(1'b1, 1'b0);
        repeat (20) drive(1'b0, 1'b0);

        // Random play.
        hitLvl = 1'b0;
        repeat (1500) begin
            if ($urandom_range(0, 4) == 0) hitLvl = ~hitLvl;
            drive(1'($urandom_range(0, 19) == 0), hitLvl);
        end

        @(posedge CLK); #3;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL queueDrain: got %0d pending, expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/snake_game_sequencer.md
Name: snake_game_sequencer

Overview:
- Top-level game controller for the snake datapath. Owns the master state (IDLE/PLAY/WIN) and generates the single-cycle game-tick strobe that advances the snake.
- Counts apples eaten into SCORE, requests a new apple position, and declares a win at a target score.
- Sits between the button/debounce logic and the snake datapath, VGA colour mux and score display. All logic is on the one system clock.

Parameters:
- TICK_DIV, 10000000: CLK cycles per game tick at score 0 (100 ms at 100 MHz).
- TARGET_SCORE, 10: score at which PLAY moves to WIN. Legal range 1..15.
- SPEED_STEP, 500000: tick-period reduction per point (used only with the optional feature).
- MIN_TICK, 2000000: floor on the tick period (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- BTN_START  in  1  start/restart button, already debounced and synchronous to CLK.
- REACHED_TARGET  in  1  level from the snake datapath; high while the head is on the apple.
- MASTER_STATE  out  2  0=IDLE, 1=PLAY, 2=WIN.
- GAME_TICK  out  1  one-CLK strobe; the snake advances once per strobe.
- SCORE  out  4  apples eaten this game.
- NEW_APPLE  out  1  one-CLK strobe; the apple logic latches a new random position on it.
- WIN_FLASH  out  1  square wave used by the colour mux in WIN.

Behaviour:
- Reset (RESET low, asynchronous): MASTER_STATE=0, SCORE=0, GAME_TICK=0, NEW_APPLE=0, WIN_FLASH=0. The tick counter, the latched period and both edge-detect registers are also cleared to 0.
- Edge detection: BTN_START and REACHED_TARGET are each registered every cycle.
  - start_edge = BTN_START & ~BTN_START_q.
  - hit_edge = REACHED_TARGET & ~REACHED_TARGET_q.
  - A level held high produces exactly one event.
- All outputs are registered. An event sampled at edge N becomes visible after edge N.
- Tick counter:
  - Counts 0..period-1 only in PLAY and WIN; it is held at 0 in IDLE.
  - At the wrap (count==period-1) the counter returns to 0 and period is re-latched.
  - In PLAY the wrap cycle pulses GAME_TICK high for exactly 1 cycle, so the tick interval is exactly period cycles.
- IDLE:
  - SCORE is held at 0; no GAME_TICK.
  - start_edge moves to PLAY and pulses NEW_APPLE in the same update. The tick counter starts from 0, so the first GAME_TICK comes period cycles after entering PLAY.
- PLAY:
  - On hit_edge: SCORE increments and NEW_APPLE pulses.
  - If SCORE+1 == TARGET_SCORE: move to WIN and do not pulse NEW_APPLE.
  - start_edge is ignored.
  - hit_edge coinciding with a wrap: both the tick and the score update happen in that cycle.
  - SCORE never exceeds TARGET_SCORE.
- WIN:
  - GAME_TICK is suppressed and SCORE is frozen.
  - WIN_FLASH toggles at each counter wrap.
  - start_edge moves to IDLE and clears SCORE, the tick counter and WIN_FLASH.
- MASTER_STATE value 3 (unreachable) goes to IDLE on the next edge.
- Reset asserted mid-game returns to the IDLE reset values at once, with no strobes.
- Width rules:
  - The counter and the latched period are 24 bits.
  - Period arithmetic is unsigned with no wrap; the result is clamped as described under Optional Feature.

Optional Feature:
- Macro: SNAKE_SPEEDUP_EN.
- Defined: period = max(MIN_TICK, TICK_DIV - SCORE*SPEED_STEP), computed with enough width that the subtraction cannot underflow. It is re-latched only at a wrap or on entry to PLAY, so a tick already in progress is never shortened.
- Undefined: period = TICK_DIV constantly; SPEED_STEP and MIN_TICK are unused.

Test Plan:
- Bench parameters: TICK_DIV=8, TARGET_SCORE=3, SPEED_STEP=2, MIN_TICK=4.
1. Release reset, hold BTN_START=0 for 50 cycles -> MASTER_STATE=0, no GAME_TICK or NEW_APPLE, SCORE=0.
2. Pulse BTN_START for 1 cycle -> MASTER_STATE=1 and NEW_APPLE high for 1 cycle. GAME_TICK first fires 8 cycles later, then every 8 cycles, with width 1.
3. In PLAY, hold REACHED_TARGET high for 20 cycles -> SCORE goes 0 to 1 exactly once and NEW_APPLE pulses once. Hold BTN_START high throughout -> no state change.
4. Three separate REACHED_TARGET pulses -> SCORE=3, MASTER_STATE=2, no NEW_APPLE on the third hit, GAME_TICK stops, WIN_FLASH toggles every 8 cycles. Then a BTN_START pulse -> MASTER_STATE=0, SCORE=0.
5. With SNAKE_SPEEDUP_EN defined, measure the tick interval at scores 0, 1, 2 -> 8, 6, 4 cycles. The new interval starts at the wrap after the hit. Without the macro -> 8 cycles at every score.
6. Assert RESET low mid-PLAY at SCORE=2, asynchronously between clock edges -> all outputs 0 immediately. After release, a BTN_START pulse starts a new game from SCORE=0.
